// File: rtl/multi_latch_bank_pkg.sv
// Shared definitions for the multi-entry latch bank: operation encodings and
// small decode helpers used by the bank top and its entries.
package multi_latch_bank_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // Only INC samples a new wrap flag; every other op leaves carry alone.
  function automatic logic op_updates_carry(input logic [1:0] op);
    return (op == OP_INC);
  endfunction

endpackage

// File: rtl/multi_latch_bank_if.sv
// Bus bundle between a datapath controller (master) and the latch bank (slave).
interface multi_latch_bank_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int NOUT  = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]      in;
  logic                  hold;
  logic [1:0]            op;
  logic [AW-1:0]         wsel;
  logic [NOUT*AW-1:0]    rsel;
  logic [NOUT-1:0]       oe;
  logic [NOUT*WIDTH-1:0] out;
  logic [DEPTH-1:0]      valid;
  logic                  carry;

  modport master (
    output in, hold, op, wsel, rsel, oe,
    input  out, valid, carry
  );

  modport slave (
    input  in, hold, op, wsel, rsel, oe,
    output out, valid, carry
  );

endinterface

// File: rtl/multi_latch_bank_latch_entry.sv
// One bank entry: a WIDTH-bit register with LOAD/INC/CLR handling, a valid bit,
// and an all-ones flag the bank uses to form its INC wrap carry.
module latch_entry
  import multi_latch_bank_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             all_ones
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             valid_q;
  logic             valid_d;

  // Next-state decode; an unselected entry never changes.
  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    if (sel) begin
      case (op)
        OP_LOAD: begin
          value_d = load_data;
          valid_d = 1'b1;
        end
        OP_INC: begin
          value_d = value_q + {{(WIDTH-1){1'b0}}, 1'b1};
          valid_d = 1'b1;
        end
        OP_CLR: begin
          value_d = {WIDTH{1'b0}};
          valid_d = 1'b0;
        end
        default: begin
          value_d = value_q;
          valid_d = valid_q;
        end
      endcase
    end else begin
      value_d = value_q;
      valid_d = valid_q;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign value    = value_q;
  assign valid    = valid_q;
  assign all_ones = &value_q;

endmodule

// File: rtl/multi_latch_bank.sv
// Bank of DEPTH latch entries fed from a shared input hold stage, with NOUT
// independently addressed read ports that drive zero when not enabled.
module multi_latch_bank
  import multi_latch_bank_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int NOUT  = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input logic              CLK,
  input logic              RESET_N,
  multi_latch_bank_if.slave bus
);

  logic [WIDTH-1:0]      holdreg_q;
  logic [WIDTH-1:0]      holdreg_d;
  logic                  carry_q;
  logic                  carry_d;
  logic [WIDTH-1:0]      entry_value_s [DEPTH];
  logic [DEPTH-1:0]      entry_valid_s;
  logic [DEPTH-1:0]      entry_all_ones_s;
  logic [NOUT*WIDTH-1:0] out_s;

  // Hold stage captures every cycle unless frozen.
  always_comb begin
    if (bus.hold) begin
      holdreg_d = holdreg_q;
    end else begin
      holdreg_d = bus.in;
    end
  end

  // Carry samples the target entry's wrap condition on INC only.
  always_comb begin
    if (op_updates_carry(bus.op)) begin
      carry_d = entry_all_ones_s[bus.wsel];
    end else begin
      carry_d = carry_q;
    end
  end

  // Hold stage and carry registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      holdreg_q <= {WIDTH{1'b0}};
      carry_q   <= 1'b0;
    end else begin
      holdreg_q <= holdreg_d;
      carry_q   <= carry_d;
    end
  end

  // Entries load the pre-edge holdreg, so in -> entry takes two edges.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    latch_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .sel       (bus.wsel == AW'(e)),
      .op        (bus.op),
      .load_data (holdreg_q),
      .value     (entry_value_s[e]),
      .valid     (entry_valid_s[e]),
      .all_ones  (entry_all_ones_s[e])
    );
  end

  // Read ports see stored state only, so a same-cycle write is not bypassed.
  always_comb begin
    out_s = {(NOUT*WIDTH){1'b0}};
    for (int k = 0; k < NOUT; k++) begin
      if (bus.oe[k]) begin
        out_s[k*WIDTH +: WIDTH] = entry_value_s[bus.rsel[k*AW +: AW]];
      end else begin
        out_s[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end
    end
  end

  assign bus.out   = out_s;
  assign bus.valid = entry_valid_s;
  assign bus.carry = carry_q;

endmodule
